// File: rtl/ule4_share_arb.sv
// Round-robin arbiter that shares one 4-bit unsigned A<=B comparator among N requesters.
// Latency: ACK two cycles after the grant edge, one result per 3 cycles; requesters hold REQ until ACK.

module ule4 (
   input  logic [3:0] i0,
   input  logic [3:0] i1,
   output logic       o
);
   logic [4:0] sum;

   // i1 - i0 with carry-in 1; the carry-out is set exactly when i1 >= i0
   assign sum = {1'b0, i1} + {1'b0, ~i0} + 5'd1;
   assign o   = sum[4];
endmodule

module ule4_share_arb #(
   parameter int N = 4
) (
   input  logic           CLK,
   input  logic           RESETN,
   input  logic [N-1:0]   REQ,
   input  logic [4*N-1:0] A,
   input  logic [4*N-1:0] B,
   output logic [N-1:0]   GNT,
   output logic [N-1:0]   ACK,
   output logic           O,
   output logic           BUSY
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [PW-1:0] ptr;
   logic [PW-1:0] sel;
   logic [PW-1:0] win_idx;
   logic          win_hit;
   logic [3:0]    a_q;
   logic [3:0]    b_q;
   logic          res_q;
   logic          cmp_o;
   logic [N-1:0]  sel_oh;

   ule4 u_ule4 (
      .i0 (a_q),
      .i1 (b_q),
      .o  (cmp_o)
   );

   // first set REQ bit at or above ptr, wrapping round
   always_comb begin
      win_idx = '0;
      win_hit = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!win_hit && REQ[(int'(ptr) + k) % N]) begin
            win_hit = 1'b1;
            win_idx = PW'((int'(ptr) + k) % N);
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_hit) state_d = CMP;
         CMP:     state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         ptr   <= '0;
         sel   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_hit) begin
                  sel <= win_idx;
                  a_q <= A[4*int'(win_idx) +: 4];
                  b_q <= B[4*int'(win_idx) +: 4];
               end
            end
            CMP:  res_q <= cmp_o;
            RESP: ptr <= (int'(sel) == N-1) ? '0 : sel + PW'(1);
            default: ;
         endcase
      end
   end

   assign sel_oh = {{(N-1){1'b0}}, 1'b1} << sel;
   assign GNT    = (state_q == CMP || state_q == RESP) ? sel_oh : '0;
   assign ACK    = (state_q == RESP) ? sel_oh : '0;
   assign O      = res_q;
   assign BUSY   = (state_q != IDLE);
endmodule

// File: tb/tb_ule4_share_arb.sv
// Bench for ule4_share_arb: per-cycle comparison against a transaction-level model plus directed literal checks.
module tb_ule4_share_arb;
   localparam int N = 4;

   logic           CLK = 1'b0;
   logic           RESETN;
   logic [N-1:0]   REQ;
   logic [4*N-1:0] A;
   logic [4*N-1:0] B;
   logic [N-1:0]   GNT;
   logic [N-1:0]   ACK;
   logic           O;
   logic           BUSY;

   int errors = 0;
   int checks = 0;

   ule4_share_arb #(.N(N)) dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .REQ    (REQ),
      .A      (A),
      .B      (B),
      .GNT    (GNT),
      .ACK    (ACK),
      .O      (O),
      .BUSY   (BUSY)
   );

   initial forever #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: a grant at edge g owns the comparator for edges g..g+2.
   int  cyc   = 0;
   bit  m_act = 1'b0;
   int  m_id  = 0;
   int  m_gc  = 0;
   int  m_ptr = 0;
   bit  m_res = 1'b0;

   initial forever begin
      @(posedge CLK or negedge RESETN);
      if (!RESETN) begin
         m_act = 1'b0;
         m_ptr = 0;
      end else begin
         bit found;
         cyc++;
         if (m_act && cyc == m_gc + 2) m_ptr = (m_id + 1) % N;
         if (!m_act || cyc >= m_gc + 3) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (!found && REQ[j]) begin
                  found = 1'b1;
                  m_id  = j;
                  m_gc  = cyc;
                  m_res = (A[4*j +: 4] <= B[4*j +: 4]);
               end
            end
            m_act = found;
         end
      end
   end

   int clk_cnt = 0;
   int log_clk[$];
   int log_id[$];
   int log_o[$];

   initial forever begin
      int exp_gnt, exp_ack, id;
      @(negedge CLK);
      clk_cnt++;
      exp_gnt = (m_act && (cyc == m_gc || cyc == m_gc + 1)) ? (1 << m_id) : 0;
      exp_ack = (m_act && cyc == m_gc + 1) ? (1 << m_id) : 0;
      chk("gnt", int'(GNT), exp_gnt);
      chk("ack", int'(ACK), exp_ack);
      chk("busy", int'(BUSY), int'(exp_gnt != 0));
      if (!RESETN) chk("o_in_reset", int'(O), 0);
      if (exp_ack != 0) chk("o", int'(O), int'(m_res));
      if (ACK != '0) begin
         id = -1;
         for (int i = 0; i < N; i++) if (ACK[i]) id = i;
         log_clk.push_back(clk_cnt);
         log_id.push_back(id);
         log_o.push_back(int'(O));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic set_op(input int id, input int a, input int b);
      A[4*id +: 4] = 4'(a);
      B[4*id +: 4] = 4'(b);
   endtask

   task automatic one_req(input string name, input int id, input int a, input int b,
                          input int exp_o);
      int n;
      n = log_id.size();
      set_op(id, a, b);
      REQ = N'(1 << id);
      tick(1);
      REQ = '0;
      tick(4);
      chk({name, "_cnt"}, log_id.size() - n, 1);
      if (log_id.size() > n) begin
         chk({name, "_id"}, log_id[n], id);
         chk({name, "_o"}, log_o[n], exp_o);
      end
   endtask

   initial begin
      int n, n3;
      int exp_id[5];
      int exp_o[5];
      exp_id = '{0, 1, 2, 3, 0};
      exp_o  = '{1, 0, 1, 0, 1};

      RESETN = 1'b0;
      REQ    = '0;
      A      = '0;
      B      = '0;
      tick(2);
      chk("rst_gnt", int'(GNT), 0);
      chk("rst_ack", int'(ACK), 0);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_o", int'(O), 0);

      // all four held from reset release: pairs (3,5) (7,2) (9,9) (15,0)
      A      = 16'hF973;
      B      = 16'h0925;
      REQ    = 4'b1111;
      RESETN = 1'b1;
      tick(14);
      REQ = '0;
      tick(4);
      chk("fair_cnt", log_id.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < log_id.size()) begin
            chk("fair_id", log_id[i], exp_id[i]);
            chk("fair_o", log_o[i], exp_o[i]);
            if (i > 0) chk("fair_gap", log_clk[i] - log_clk[i-1], 3);
         end
      end

      // single request, cycle by cycle
      set_op(0, 3, 5);
      REQ = 4'b0001;
      @(posedge CLK);
      #2;
      REQ = '0;
      @(negedge CLK);
      chk("single_gnt1", int'(GNT), 1);
      chk("single_ack1", int'(ACK), 0);
      chk("single_busy1", int'(BUSY), 1);
      @(negedge CLK);
      chk("single_gnt2", int'(GNT), 1);
      chk("single_ack2", int'(ACK), 1);
      chk("single_o", int'(O), 1);
      @(negedge CLK);
      chk("single_gnt3", int'(GNT), 0);
      chk("single_busy3", int'(BUSY), 0);
      tick(2);

      one_req("b_9_9", 2, 9, 9, 1);
      one_req("b_15_0", 2, 15, 0, 0);
      one_req("b_0_15", 2, 0, 15, 1);
      one_req("b_8_7", 2, 8, 7, 0);

      // operands changed right after the grant edge must not matter
      n = log_id.size();
      set_op(1, 2, 1);
      REQ = 4'b0010;
      tick(1);
      set_op(1, 0, 1);
      REQ = '0;
      tick(4);
      chk("latch_cnt", log_id.size() - n, 1);
      if (log_id.size() > n) chk("latch_o", log_o[n], 0);

      // REQ[3] pulsed only while requester 0 is in CMP
      n = log_id.size();
      set_op(0, 3, 5);
      REQ = 4'b0001;
      tick(1);
      REQ = 4'b1000;
      tick(1);
      REQ = '0;
      tick(8);
      n3 = 0;
      for (int i = n; i < log_id.size(); i++) if (log_id[i] == 3) n3++;
      chk("drop_cnt", log_id.size() - n, 1);
      chk("drop_r3", n3, 0);

      // reset while requester 2 is in CMP
      n = log_id.size();
      set_op(2, 0, 15);
      REQ = 4'b0100;
      tick(1);
      REQ    = '0;
      RESETN = 1'b0;
      #1;
      chk("mrst_gnt", int'(GNT), 0);
      chk("mrst_ack", int'(ACK), 0);
      chk("mrst_busy", int'(BUSY), 0);
      chk("mrst_o", int'(O), 0);
      tick(1);
      set_op(1, 6, 4);
      REQ    = 4'b0010;
      RESETN = 1'b1;
      tick(1);
      REQ = '0;
      tick(4);
      chk("mrst_cnt", log_id.size() - n, 1);
      if (log_id.size() > n) begin
         chk("mrst_id", log_id[n], 1);
         chk("mrst_o_after", log_o[n], 0);
      end

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ule4_share_arb.md
# ule4_share_arb

Round-robin arbiter and sequencer that shares one `ULE4` unsigned 4-bit less-or-equal comparator among N requesters. Each requester presents an operand pair and holds a request until it receives a one-cycle acknowledge carrying the compare result. The block sits between several small control units and the single carry-chain comparator instance, and serialises their compares at one result every 3 cycles.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `CLK`  in  1  rising-edge clock.
- `RESETN`  in  1  asynchronous, active-low reset.
- `REQ`  in  N  per-requester compare request, level-sensitive.
- `A`  in  4N  packed operand A; requester i uses `A[4i+3:4i]`.
- `B`  in  4N  packed operand B; requester i uses `B[4i+3:4i]`.
- `GNT`  out  N  one-hot; identifies the requester being served in CMP and RESP states.
- `ACK`  out  N  one-hot, one-cycle pulse; the result is valid for requester i.
- `O`  out  1  compare result, 1 when A ≤ B (unsigned).
- `BUSY`  out  1  high whenever the state is not IDLE.

## Operation
- Single shared `ULE4` instance:
  - `I0` = latched A.
  - `I1` = latched B.
  - `O` = A ≤ B, computed as the carry-out of B − A with carry-in 1.
- State machine, 2-bit state register:
  - IDLE: if any `REQ` bit is high, select the winner, latch `A`/`B` slices, latch `sel`, go to CMP. Otherwise stay in IDLE.
  - CMP: capture the comparator output into `res_q`, go to RESP.
  - RESP: `ACK[sel]` = 1, `O` = `res_q`, set `ptr` ← (`sel`+1) mod N, go to IDLE.
- Arbitration is round-robin over `REQ`.
  - Search starts at `ptr` and ascends with wrap. The first set bit wins.
  - `ptr` = 0 after reset.
  - `ptr` updates only in RESP.
- Operands are latched at grant. Changes to `A`/`B` after the grant edge do not affect the result.
- `REQ` is sampled only in IDLE.
  - A request dropped before its grant is lost, with no ACK.
  - A request dropped after its grant is still completed and acknowledged.
- A requester holding `REQ` through its ACK is treated as a new request in the following IDLE cycle. Round-robin order gives the other requesters priority.
- `GNT[sel]` is high in CMP and RESP. It is 0 in IDLE.
- `O` holds `res_q`, which keeps its value until the next CMP. `O` is meaningful only while `ACK` is high.
- Width rules: unsigned 4-bit compare. No sign extension and no overflow; all 256 operand pairs are legal.
- Reset (`RESETN` low, asynchronous, at any time, including mid-CMP or mid-RESP):
  - state = IDLE, `ptr` = 0, `sel` = 0, `res_q` = 0, operand registers = 0.
  - `GNT` = 0, `ACK` = 0, `O` = 0, `BUSY` = 0 immediately.
  - An in-flight transaction is discarded with no ACK.
  - Release is synchronous to the next `CLK` edge. The first grant is possible at the first rising edge after deassertion.

## Timing
- `REQ[i]` high and winning at rising edge t (state IDLE):
  - `GNT[i]` and `BUSY` high during cycles t+1 and t+2.
  - `ACK[i]` and valid `O` during cycle t+2 only.
  - State is IDLE again in cycle t+3.
- Latency is 2 cycles from grant edge to ACK. Throughput is 1 transaction per 3 cycles.
- With N requests held continuously, each requester receives one ACK every 3N cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from `REQ`, `A` or `B` to any output.
- The comparator path (4-bit carry chain) must close timing in one cycle at the target clock.

## Test plan
- Single request: `REQ`=0001, A0=3, B0=5 → `ACK`=0001 two cycles after the grant edge, `O`=1, `GNT`=0001 for 2 cycles.
- Boundary values on requester 2:
  - A=9, B=9 → `O`=1.
  - A=15, B=0 → `O`=0.
  - A=0, B=15 → `O`=1.
  - A=8, B=7 → `O`=0.
- Fairness: `REQ`=1111 held from reset release → ACK order 0,1,2,3,0 at 3-cycle spacing; `O` correct per operand pair.
- Operand change after grant: grant requester 1 with A=2, B=1, then drive A=0 in the next cycle → `O`=0, using the latched values.
- Dropped request: pulse `REQ[3]` for 1 cycle while requester 0 is in CMP → no ACK ever appears for requester 3.
- Reset mid-CMP: assert `RESETN`=0 in cycle t+1 → `GNT`/`ACK`/`BUSY`/`O` go to 0 immediately. After release with `REQ`=0010, requester 1 is served first, because the round-robin search starts at `ptr`=0 and requester 1 holds the only set bit.
